wb_rst_seq: RTL and testbench

- Synthesizable, parametrised reset sequencer for the WB DMA environment.
- Generalises single fixed-delay reset generation to NUM_RST reset domains.
- Releases the domains in staggered ascending order after a configurable hold delay.
- Supports a software-requested partial reset of selected domains. Sits between the global reset source and the DMA/WB master/slave blocks.

---
 rtl/wb_rst_seq.sv | 129 ++++++++++++
 tb/tb_wb_rst_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_rst_seq.sv
// wb_rst_seq: multi-domain reset sequencer.
// After the global reset is synchronously deasserted, all domains are held
// for RST_DELAY cycles. They are then released one at a time in ascending
// index order, STAGGER cycles apart. Software may re-reset a subset of
// domains once the sequence has finished.
//
// Request handshake: sw_rst_req is a single-cycle strobe with no ready. It is
// accepted only on an edge where the FSM is in IDLE and sw_rst_mask is
// non-zero, and sw_rst_mask is sampled on that same edge. Requests arriving
// at any other time are dropped and never queued.
module wb_rst_seq #(
   parameter int NUM_RST     = 4,
   parameter int RST_DELAY   = 50,
   parameter int STAGGER     = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               sw_rst_req,
   input  logic [NUM_RST-1:0] sw_rst_mask,
   output logic [NUM_RST-1:0] rst_out,
   output logic               rst_done,
   output logic               busy
);

   localparam int MAX_CNT = (RST_DELAY > STAGGER) ? RST_DELAY : STAGGER;
   localparam int CW      = $clog2(MAX_CNT + 1);

   localparam logic [CW-1:0]      HOLD_TC = CW'(RST_DELAY - 1);
   localparam logic [CW-1:0]      STAG_TC = CW'(STAGGER - 1);
   localparam logic [CW-1:0]      CNT_ONE = CW'(1);
   localparam logic [NUM_RST-1:0] VEC_ONE = NUM_RST'(1);

   typedef enum logic [1:0] {
      SYNC = 2'd0,
      HOLD = 2'd1,
      REL  = 2'd2,
      IDLE = 2'd3
   } state_t;

   state_t               state, state_n;
   logic [CW-1:0]        cnt, cnt_n;
   logic [NUM_RST-1:0]   rst_out_n;
   logic                 rst_done_n, busy_n;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                 rst_sync;
   logic                 tc_hit;
   logic [NUM_RST-1:0]   remaining;

   // Deassertion synchronizer: async-set by rst, shifts zeros in afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= '1;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
   end

   assign rst_sync = sync_q[SYNC_STAGES-1];

   // rst_out doubles as the set of domains still waiting for release, so
   // clearing its lowest set bit releases the next domain in index order and
   // skips unmasked domains without spending any cycles on them.
   assign remaining = rst_out & (rst_out - VEC_ONE);

   // The counter has reached its terminal count for the current state.
   assign tc_hit = ((state == HOLD) && (cnt >= HOLD_TC)) ||
                   ((state == REL)  && (cnt >= STAG_TC));

   // State, counter and registered outputs; rst returns everything to power-on.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= SYNC;
         cnt      <= '0;
         rst_out  <= '1;
         rst_done <= 1'b0;
         busy     <= 1'b1;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         rst_out  <= rst_out_n;
         rst_done <= rst_done_n;
         busy     <= busy_n;
      end
   end

   // Next-state, counter and output decisions.
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      rst_out_n  = rst_out;
      rst_done_n = rst_done;
      busy_n     = busy;
      case (state)
         SYNC: begin
            if (!rst_sync) begin
               state_n = HOLD;
               cnt_n   = '0;
            end
         end
         HOLD, REL: begin
            if (tc_hit) begin
               rst_out_n = remaining;
               cnt_n     = '0;
               if (remaining == '0) begin
                  state_n    = IDLE;
                  rst_done_n = 1'b1;
                  busy_n     = 1'b0;
               end else begin
                  state_n = REL;
               end
            end else begin
               cnt_n = cnt + CNT_ONE;
            end
         end
         IDLE: begin
            if (sw_rst_req && (sw_rst_mask != '0)) begin
               rst_out_n  = rst_out | sw_rst_mask;
               rst_done_n = 1'b0;
               busy_n     = 1'b1;
               state_n    = HOLD;
               cnt_n      = '0;
            end
         end
         default: begin
            state_n = SYNC;
            cnt_n   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_wb_rst_seq.sv
// Testbench for wb_rst_seq: a default instance and a parameter-sweep
// instance, checked cycle by cycle against release-time arithmetic.
`timescale 1ns/100ps
module tb_wb_rst_seq;

   localparam int N = 4,  D = 50, G = 4, S = 2;
   localparam int PN = 8, PD = 3, PG = 1, PS = 3;

   logic          clk;
   logic          rst, sw_rst_req;
   logic [N-1:0]  sw_rst_mask, rst_out;
   logic          rst_done, busy;
   logic          rst2, sw_rst_req2;
   logic [PN-1:0] sw_rst_mask2, rst_out2;
   logic          rst_done2, busy2;

   int n_checks = 0;
   int n_fail   = 0;

   wb_rst_seq #(.NUM_RST(N), .RST_DELAY(D), .STAGGER(G), .SYNC_STAGES(S)) dut (
      .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req), .sw_rst_mask(sw_rst_mask),
      .rst_out(rst_out), .rst_done(rst_done), .busy(busy));

   wb_rst_seq #(.NUM_RST(PN), .RST_DELAY(PD), .STAGGER(PG), .SYNC_STAGES(PS)) dut_p (
      .clk(clk), .rst(rst2), .sw_rst_req(sw_rst_req2), .sw_rst_mask(sw_rst_mask2),
      .rst_out(rst_out2), .rst_done(rst_done2), .busy(busy2));

   // clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: the j-th masked domain (ascending index) is released at
   // relative edge base + j*stagger; a bit reads 1 after edge k while k is
   // below its release edge. Unmasked domains are always 0.
   function automatic logic [31:0] exp_vec(int n, int base, int g, logic [31:0] mask, int k);
      int j;
      logic [31:0] v;
      j = 0;
      v = '0;
      for (int i = 0; i < n; i++) begin
         if (mask[i]) begin
            if (k < base + j * g) v[i] = 1'b1;
            j++;
         end
      end
      return v;
   endfunction

   function automatic logic exp_done(int n, int base, int g, logic [31:0] mask, int k);
      int m;
      m = 0;
      for (int i = 0; i < n; i++) if (mask[i]) m++;
      return (m == 0) || (k >= base + (m - 1) * g);
   endfunction

   task automatic test_reset();
      rst = 1'b1; rst2 = 1'b1;
      sw_rst_req = 1'b0; sw_rst_mask = '0;
      sw_rst_req2 = 1'b0; sw_rst_mask2 = '0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         if (c == 2) begin sw_rst_req = 1'b1; sw_rst_mask = 4'b1111; end
         if (c == 3) sw_rst_req = 1'b0;
         n_checks++;
         if (rst_out !== 4'b1111 || rst_done !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_hold c=%0d got out=%b done=%b busy=%b want 1111/0/1",
                     c, rst_out, rst_done, busy);
         end
         n_checks++;
         if (rst_out2 !== 8'hFF || rst_done2 !== 1'b0 || busy2 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_hold_p c=%0d got out=%h done=%b busy=%b want ff/0/1",
                     c, rst_out2, rst_done2, busy2);
         end
      end
   endtask

   // Deasserts rst (called at posedge+1, so the next edge is E0) and checks
   // every cycle. req_at >= 1 injects an ignored request at that edge;
   // abort_at >= 0 re-asserts rst after that edge and stops.
   task automatic test_power_on(int abort_at, int req_at);
      logic [31:0] e;
      logic        ed;
      int          last;
      last = S + D + (N - 1) * G + 4;
      rst = 1'b0;
      for (int k = 0; k <= last; k++) begin
         @(posedge clk); #1;
         if (k == req_at) sw_rst_req = 1'b0;
         e  = exp_vec(N, S + D, G, 32'hFFFF_FFFF, k);
         ed = exp_done(N, S + D, G, 32'hFFFF_FFFF, k);
         n_checks++;
         if (rst_out !== e[N-1:0]) begin
            n_fail++;
            $display("FAIL power_on_rst_out k=%0d got %b want %b", k, rst_out, e[N-1:0]);
         end
         n_checks++;
         if (rst_done !== ed || busy !== !ed) begin
            n_fail++;
            $display("FAIL power_on_done_busy k=%0d got done=%b busy=%b want done=%b busy=%b",
                     k, rst_done, busy, ed, !ed);
         end
         if (k == req_at - 1) begin
            sw_rst_req  = 1'b1;
            sw_rst_mask = 4'($urandom_range(1, 15));
         end
         if (k == abort_at) begin
            rst = 1'b1;
            #1;
            n_checks++;
            if (rst_out !== 4'b1111 || rst_done !== 1'b0 || busy !== 1'b1) begin
               n_fail++;
               $display("FAIL mid_reset_async k=%0d got out=%b done=%b busy=%b want 1111/0/1",
                        k, rst_out, rst_done, busy);
            end
            break;
         end
      end
   endtask

   // Software reset from IDLE; the request edge is relative edge 0.
   task automatic test_sw_reset(logic [N-1:0] mask);
      logic [31:0] e, m32;
      logic        ed;
      m32 = 32'(mask);
      sw_rst_req  = 1'b1;
      sw_rst_mask = mask;
      for (int k = 0; k <= D + N * G + 3; k++) begin
         @(posedge clk); #1;
         sw_rst_req = 1'b0;
         e  = exp_vec(N, D, G, m32, k);
         ed = exp_done(N, D, G, m32, k);
         n_checks++;
         if (rst_out !== e[N-1:0]) begin
            n_fail++;
            $display("FAIL sw_rst_out mask=%b k=%0d got %b want %b", mask, k, rst_out, e[N-1:0]);
         end
         n_checks++;
         if (rst_done !== ed || busy !== !ed) begin
            n_fail++;
            $display("FAIL sw_done_busy mask=%b k=%0d got done=%b busy=%b want done=%b busy=%b",
                     mask, k, rst_done, busy, ed, !ed);
         end
      end
   endtask

   task automatic test_hold_request();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      test_power_on(-1, int'($urandom_range(1, 63)));
   endtask

   task automatic test_mid_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      test_power_on(58, -1);
      repeat (4) @(posedge clk);
      #1;
      test_power_on(-1, -1);
   endtask

   // 1 ns rst pulse between edges while in IDLE.
   task automatic test_glitch();
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (rst_out !== 4'b1111 || rst_done !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL glitch_async got out=%b done=%b busy=%b want 1111/0/1",
                  rst_out, rst_done, busy);
      end
      test_power_on(-1, -1);
   endtask

   task automatic test_sweep();
      logic [31:0] e, m32;
      logic        ed;
      @(posedge clk); #1;
      rst2 = 1'b0;
      for (int k = 0; k <= PS + PD + (PN - 1) * PG + 3; k++) begin
         @(posedge clk); #1;
         e  = exp_vec(PN, PS + PD, PG, 32'hFFFF_FFFF, k);
         ed = exp_done(PN, PS + PD, PG, 32'hFFFF_FFFF, k);
         n_checks++;
         if (rst_out2 !== e[PN-1:0] || rst_done2 !== ed || busy2 !== !ed) begin
            n_fail++;
            $display("FAIL sweep_power_on k=%0d got out=%h done=%b busy=%b want out=%h done=%b busy=%b",
                     k, rst_out2, rst_done2, busy2, e[PN-1:0], ed, !ed);
         end
      end
      m32 = 32'($urandom_range(1, 255));
      sw_rst_req2  = 1'b1;
      sw_rst_mask2 = m32[PN-1:0];
      for (int k = 0; k <= PD + PN * PG + 2; k++) begin
         @(posedge clk); #1;
         sw_rst_req2 = 1'b0;
         e  = exp_vec(PN, PD, PG, m32, k);
         ed = exp_done(PN, PD, PG, m32, k);
         n_checks++;
         if (rst_out2 !== e[PN-1:0] || rst_done2 !== ed || busy2 !== !ed) begin
            n_fail++;
            $display("FAIL sweep_sw mask=%h k=%0d got out=%h done=%b busy=%b want out=%h done=%b busy=%b",
                     m32[PN-1:0], k, rst_out2, rst_done2, busy2, e[PN-1:0], ed, !ed);
         end
      end
   endtask

   initial begin
      test_reset();
      test_power_on(-1, -1);
      test_sw_reset(4'b1010);
      test_sw_reset(4'b0000);
      test_sw_reset(4'b1111);
      test_sw_reset(4'b1000);
      for (int r = 0; r < 3; r++) test_sw_reset(4'($urandom_range(1, 15)));
      test_hold_request();
      test_hold_request();
      test_mid_reset();
      test_glitch();
      test_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
